// File: rtl/counter_prog.sv
// Programmable up/down counter with one-shot and auto-reload modes.
// Ports: clock_i, reset_i (sync, active-high), enable_i, dir_i, reload_i,
//   load_i, load_val_i, max_i, cmp_i -> counter_val_o, tc_o, finished_o,
//   busy_o, match_o (combinational compare).
module counter_prog #(
   parameter int WIDTH = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             dir_i,
   input  logic             reload_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] max_i,
   input  logic [WIDTH-1:0] cmp_i,
   output logic [WIDTH-1:0] counter_val_o,
   output logic             tc_o,
   output logic             finished_o,
   output logic             busy_o,
   output logic             match_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             tc_q;
   logic             tc_d;

   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] step_val;
   logic             at_term;
   logic             lands;

   assign term_val  = dir_i ? '0 : max_i;
   assign start_val = dir_i ? max_i : '0;

   // Counting up from above the limit is treated as already terminal,
   // so an up step can never wrap past max_i.
   assign at_term = dir_i ? (cnt_q == '0) : (cnt_q >= max_i);

   // Only used when not at terminal, so neither direction can wrap.
   assign step_val = dir_i ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
   assign lands    = (step_val == term_val);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      if (load_i) begin
         cnt_d   = load_val_i;
         state_d = IDLE;
      end else if (enable_i && (state_q != DONE)) begin
         if (at_term) begin
            // Reload restarts silently; one-shot finishes holding value.
            if (reload_i) begin
               cnt_d   = start_val;
               state_d = RUN;
            end else begin
               state_d = DONE;
            end
         end else begin
            cnt_d   = step_val;
            tc_d    = lands;
            state_d = (lands && !reload_i) ? DONE : RUN;
         end
      end
   end

   assign counter_val_o = cnt_q;
   assign tc_o          = tc_q;
   assign finished_o    = (state_q == DONE);
   assign busy_o        = (state_q == RUN);
   assign match_o       = (cnt_q == cmp_i);

endmodule
